// File: rtl/shift_ser_pkg.sv
// Shared constants and FSM state type for the shift-word serializer.
package shift_ser_pkg;
    localparam int BYTE_W     = 8;
    localparam int DROP_CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;
endpackage

// File: rtl/shift_word_fifo.sv
// Word buffer in front of the serializer: pointer-based FIFO, head word visible combinationally
// so the serializer can pop it straight into its holding register.
module shift_word_fifo
    import shift_ser_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the addresses match.
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
endmodule

// File: rtl/shift_word_serializer.sv
// Buffers shifted words and emits them one byte lane per handshake, lane 0 first.
// Define SHIFT_SER_DROP_CNT_EN to add the saturating drop_cnt output.
module shift_word_serializer
    import shift_ser_pkg::*;
#(
    parameter int M     = 4,
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [BYTE_W*(2**M)-1:0]      word_in,
    input  logic                          en_in,
    input  logic                          ready_in,
    output logic [BYTE_W-1:0]             byte_out,
    output logic                          valid_out,
    output logic                          last_out,
    output logic                          overflow,
    output logic                          busy
`ifdef SHIFT_SER_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]         drop_cnt
`endif
);
    localparam int N      = 2**M;
    localparam int WORD_W = BYTE_W*N;
    localparam logic [M-1:0] LAST_IDX = {M{1'b1}};

    ser_state_e         state_q, state_d;
    logic [WORD_W-1:0]  hold_q, hold_d;
    logic [M-1:0]       index_q, index_d;
    logic               overflow_q;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
    logic [WORD_W-1:0]  fifo_rdata;
    logic [BYTE_W-1:0]  lanes [N];

    shift_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (word_in),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        assign lanes[gi] = hold_q[gi*BYTE_W +: BYTE_W];
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        index_d  = index_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    hold_d   = fifo_rdata;
                    index_d  = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (ready_in) begin
                    if (index_q != LAST_IDX) begin
                        index_d = index_q + M'(1);
                    end else if (!fifo_empty) begin
                        // Reload straight from the FIFO so the word boundary has no bubble.
                        fifo_pop = 1'b1;
                        hold_d   = fifo_rdata;
                        index_d  = '0;
                    end else begin
                        index_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO still takes the word when its head leaves on the same edge.
    assign fifo_push = en_in && (!fifo_full || fifo_pop);
    assign drop      = en_in && fifo_full && !fifo_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            index_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            index_q    <= index_d;
            overflow_q <= drop;
        end
    end

    assign valid_out = (state_q == SEND);
    assign byte_out  = valid_out ? lanes[index_q] : '0;
    assign last_out  = valid_out && (index_q == LAST_IDX);
    assign overflow  = overflow_q;
    assign busy      = valid_out || !fifo_empty;

`ifdef SHIFT_SER_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
            drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_shift_word_serializer.sv
// Directed bench for shift_word_serializer (M=4, DEPTH=2); drop_cnt checked when
// SHIFT_SER_DROP_CNT_EN is defined.
module tb_shift_word_serializer;
    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] word_in;
    logic         en_in;
    logic         ready_in;
    logic [7:0]   byte_out;
    logic         valid_out;
    logic         last_out;
    logic         overflow;
    logic         busy;
`ifdef SHIFT_SER_DROP_CNT_EN
    logic [7:0]   drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    shift_word_serializer #(.M(4), .DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .word_in   (word_in),
        .en_in     (en_in),
        .ready_in  (ready_in),
        .byte_out  (byte_out),
        .valid_out (valid_out),
        .last_out  (last_out),
        .overflow  (overflow),
        .busy      (busy)
`ifdef SHIFT_SER_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Word whose lane i holds base+i.
    function automatic logic [127:0] mkword(input logic [7:0] base);
        logic [127:0] w;
        for (int i = 0; i < 16; i++) w[8*i +: 8] = base + 8'(i);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_byte(input string tag, input logic [7:0] b, input logic l);
        chk({tag, "_valid"}, 128'(valid_out), 128'(1'b1));
        chk({tag, "_byte"},  128'(byte_out),  128'(b));
        chk({tag, "_last"},  128'(last_out),  128'(l));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 128'(valid_out), 128'(1'b0));
        chk({tag, "_busy"},  128'(busy),      128'(1'b0));
        chk({tag, "_byte"},  128'(byte_out),  128'(8'h00));
        chk({tag, "_last"},  128'(last_out),  128'(1'b0));
    endtask

    initial begin
        logic [7:0] exp_idx;

        // Reset with en_in asserted: the word must be ignored.
        reset = 1'b1; en_in = 1'b1; ready_in = 1'b1; word_in = mkword(8'hF0);
        tick(); tick();
        chk_idle("rst");
        chk("rst_ovf", 128'(overflow), 128'(1'b0));
`ifdef SHIFT_SER_DROP_CNT_EN
        chk("rst_dcnt", 128'(drop_cnt), 128'(8'd0));
`endif
        reset = 1'b0; en_in = 1'b0;
        tick();
        chk_idle("post_rst");
        $display("step reset done");

        // Single word: first byte two edges after en_in is presented.
        word_in = mkword(8'h00); en_in = 1'b1; ready_in = 1'b1;
        tick();
        en_in = 1'b0;
        chk("single_lat_valid", 128'(valid_out), 128'(1'b0));
        chk("single_lat_busy",  128'(busy),      128'(1'b1));
        tick();
        for (int i = 0; i < 16; i++) begin
            chk_byte("single", 8'(i), i == 15);
            tick();
        end
        chk_idle("single_end");
        $display("step single word done");

        // Back-to-back words: 32 consecutive valid cycles.
        word_in = mkword(8'h10); en_in = 1'b1;
        tick();
        word_in = mkword(8'h20);
        tick();
        en_in = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk_byte("b2b", (i < 16) ? 8'(8'h10 + i) : 8'(8'h20 + i - 16), (i % 16) == 15);
            tick();
        end
        chk_idle("b2b_end");
        $display("step back-to-back done");

        // Backpressure: ready toggles 1,0; 16 handshakes in 31 cycles.
        word_in = mkword(8'h30); en_in = 1'b1;
        tick();
        en_in = 1'b0;
        tick();
        exp_idx = 8'd0;
        for (int c = 0; c < 31; c++) begin
            ready_in = (c % 2) == 0;
            chk_byte("bp", 8'h30 + exp_idx, exp_idx == 8'd15);
            tick();
            if (ready_in) exp_idx++;
        end
        chk("bp_count", 128'(exp_idx), 128'(8'd16));
        chk_idle("bp_end");
        ready_in = 1'b1;
        $display("step backpressure done");

        // Overflow: ready low, four words; the fourth is dropped.
        ready_in = 1'b0; en_in = 1'b1;
        word_in = mkword(8'h40); tick();
        word_in = mkword(8'h50); tick();
        word_in = mkword(8'h60); tick();
        chk("ovf_before", 128'(overflow), 128'(1'b0));
        word_in = mkword(8'h70); tick();
        en_in = 1'b0;
        chk("ovf_pulse", 128'(overflow), 128'(1'b1));
`ifdef SHIFT_SER_DROP_CNT_EN
        chk("ovf_dcnt", 128'(drop_cnt), 128'(8'd1));
`endif
        chk_byte("ovf_hold", 8'h40, 1'b0);
        tick();
        chk("ovf_clear", 128'(overflow), 128'(1'b0));
        ready_in = 1'b1;
        for (int i = 0; i < 48; i++) begin
            chk_byte("ovf_drain", 8'(8'h40 + (i / 16) * 16 + (i % 16)), (i % 16) == 15);
            tick();
        end
        chk_idle("ovf_end");
`ifdef SHIFT_SER_DROP_CNT_EN
        chk("ovf_dcnt_keep", 128'(drop_cnt), 128'(8'd1));
`endif
        $display("step overflow done");

        // Full FIFO plus pop: a word arriving with the last-byte handshake is kept.
        ready_in = 1'b0; en_in = 1'b1;
        word_in = mkword(8'h80); tick();
        word_in = mkword(8'h90); tick();
        word_in = mkword(8'hA0); tick();
        en_in = 1'b0; ready_in = 1'b1;
        for (int i = 0; i < 15; i++) begin
            chk_byte("fp_first", 8'(8'h80 + i), 1'b0);
            tick();
        end
        chk_byte("fp_lastbyte", 8'h8F, 1'b1);
        word_in = mkword(8'hB0); en_in = 1'b1;
        tick();
        en_in = 1'b0;
        chk("fp_ovf", 128'(overflow), 128'(1'b0));
        for (int i = 0; i < 48; i++) begin
            chk_byte("fp_drain", 8'(8'h90 + (i / 16) * 16 + (i % 16)), (i % 16) == 15);
            tick();
        end
        chk("fp_ovf_end", 128'(overflow), 128'(1'b0));
        chk_idle("fp_end");
        $display("step full-plus-pop done");

        // Reset mid-word with a second word buffered: both are abandoned.
        word_in = mkword(8'hC0); en_in = 1'b1;
        tick();
        en_in = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                word_in = mkword(8'hE0); en_in = 1'b1;
            end else begin
                en_in = 1'b0;
            end
            chk_byte("mid", 8'(8'hC0 + i), 1'b0);
            tick();
        end
        chk_byte("mid_pre_rst", 8'hC5, 1'b0);
        reset = 1'b1; en_in = 1'b1; word_in = mkword(8'hF0);
        tick();
        chk_idle("mid_rst");
        reset = 1'b0; en_in = 1'b0;
        tick();
        chk_idle("mid_after");
        word_in = mkword(8'hD0); en_in = 1'b1;
        tick();
        en_in = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk_byte("mid_new", 8'(8'hD0 + i), i == 15);
            tick();
        end
        chk_idle("mid_end");
        $display("step reset mid-word done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_word_serializer.md
SHIFT_WORD_SERIALIZER -- requirements
Module: shift_word_serializer

Interface
REQ-001 Parameter M, default 4, log2 of byte-lane count; N = 2**M lanes of 8 bits.
REQ-002 Parameter DEPTH, default 2, word-buffer entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 word_in  input  8*N  shifted word from the upstream barrel shifter; lane i is bits [8*i+7:8*i].
REQ-006 en_in  input  1  word_in valid this cycle; no backpressure to upstream.
REQ-007 ready_in  input  1  downstream accepts byte_out this cycle.
REQ-008 byte_out  output  8  current byte.
REQ-009 valid_out  output  1  byte_out valid.
REQ-010 last_out  output  1  byte_out is lane N-1 of its word.
REQ-011 overflow  output  1  one-cycle pulse when an incoming word is dropped.
REQ-012 busy  output  1  high when the serializer holds a word or the buffer is non-empty.

Function
REQ-013 Incoming words SHALL be written to a DEPTH-entry FIFO on any posedge where en_in=1 and the FIFO is not full.
REQ-014 If en_in=1 and the FIFO is full, the write SHALL still occur when the FIFO is popped on the same edge.
REQ-015 Otherwise the word SHALL be discarded, and overflow SHALL be 1 for exactly the following cycle.
REQ-016 The serializer SHALL have two states: IDLE and SEND.
REQ-017 IDLE->SEND SHALL occur on the edge where the FIFO is non-empty; the head word SHALL be popped into the holding register and the lane index set to 0.
REQ-018 In SEND: valid_out=1, byte_out=lane[index], and last_out=(index==N-1).
REQ-019 On valid_out&ready_in with index<N-1, index SHALL increment; otherwise all outputs SHALL hold.
REQ-020 On valid_out&ready_in with index==N-1: if the FIFO is non-empty, the next word SHALL be popped and index set to 0 in SEND with no bubble; otherwise the state SHALL go to IDLE.
REQ-021 Latency: a word written at edge k into an empty FIFO with the serializer in IDLE SHALL produce valid_out=1 after edge k+1.
REQ-022 Bytes SHALL be emitted LSB lane first (lane 0 .. lane N-1).
REQ-023 The index counter SHALL be M bits and SHALL never exceed N-1.
REQ-024 Total storage SHALL be DEPTH+1 words (FIFO plus holding register).
REQ-025 In IDLE: valid_out=0, last_out=0, byte_out=0.

Reset
REQ-026 While reset=1 at posedge: state=IDLE, FIFO empty, index=0, and all outputs 0 (byte_out=0, valid_out=0, last_out=0, overflow=0, busy=0, drop_cnt=0).
REQ-027 Reset mid-word SHALL abandon the current and all buffered words; en_in during reset SHALL be ignored.

Configuration
REQ-028 Macro SHIFT_SER_DROP_CNT_EN defined: output drop_cnt [7:0] SHALL count discarded words, saturating at 255, cleared only by reset.
REQ-029 Macro undefined: the drop_cnt port and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 Package shift_ser_pkg SHALL hold BYTE_W=8, the state enum (IDLE, SEND) and the drop-counter width of 8.
REQ-031 The FIFO SHALL be sub-module shift_word_fifo (parameters WIDTH and DEPTH; push/pop/full/empty), instantiated once.

Verification (M=4, DEPTH=2)
REQ-032 Single word: word_in=0x0F0E0D0C0B0A09080706050403020100, en_in for 1 cycle, ready_in=1 -> bytes 00..0F on 16 consecutive cycles starting 2 cycles later, last_out only on 0F, then IDLE, busy=0.
REQ-033 Back-to-back: 2 words on consecutive cycles, ready_in=1 -> 32 consecutive valid_out cycles, no bubble at the word boundary.
REQ-034 Backpressure: ready_in toggles 1,0 every cycle -> each byte is held while ready_in=0, no byte is lost or duplicated, and 16 bytes complete in 31 cycles.
REQ-035 Overflow: ready_in=0, 4 words on consecutive cycles -> first 3 accepted, 4th dropped, overflow pulses once, drop_cnt=1 (macro on); releasing ready_in then yields 48 bytes.
REQ-036 Full plus pop: FIFO full, en_in coincides with the final-byte handshake -> word accepted, overflow stays 0.
REQ-037 Reset mid-word: reset after 5 bytes sent -> next cycle valid_out=0 and busy=0; a new word then serializes from lane 0.
